ram_sp_arbiter: RTL and testbench
=================================

Name: ram_sp_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the single-port synchronous RAM (64 x 8, ports data/addr/wr/q).
- Serialises read/write requests from masters m0 and m1 onto the single RAM port.
- Issues at most one access every two cycles.
- Returns read data with a valid pulse to the master that issued the read.
- Sits between the two bus masters and the RAM instance inside the top level.

Parameters:
AW, 6, RAM address width
DW, 8, RAM data width
RD_LAT, 1, cycles from RAM address/wr sampled to q valid (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
m0_req  in  1  m0 access request, held until m0_gnt seen
m0_wr  in  1  1=write, 0=read; stable while m0_req
m0_addr  in  AW  m0 address; stable while m0_req
m0_wdata  in  DW  m0 write data; stable while m0_req
m0_gnt  out  1  one-cycle pulse: m0 access issued this cycle
m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
m0_rdata  out  DW  m0 read data, holds last value
m1_req, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for master 1
ram_addr  out  AW  RAM address
ram_data  out  DW  RAM write data
ram_wr  out  1  RAM write enable
ram_q  in  DW  RAM read data

Behaviour:
- Reset (asynchronous, any time) clears all outputs, state and read pipeline to 0:
  - FSM goes to IDLE.
  - Round-robin pointer last=1, so m0 wins the first tie.
  - In-flight reads are discarded; no rvalid after reset.
- FSM has two states, IDLE and ACCESS:
  - IDLE: on an edge with any req high, register the winner's addr, wdata and wr onto ram_*, set its gnt=1, update last=winner, go to ACCESS. With no req, stay in IDLE with outputs unchanged except gnt=0 and ram_wr=0.
  - ACCESS: lasts exactly one cycle (the access cycle A), in which gnt and the ram_* outputs are valid. At the edge ending A: gnt<=0, ram_wr<=0, go to IDLE. Requests are not sampled in ACCESS.
- Winner selection:
  - Only one req high: that master wins.
  - Both high: the master that is not the last winner wins (strict alternation under contention).
- Timing: req first sampled at edge ending cycle R gives A=R+1. Max throughput is one access per 2 cycles; each master gets at least 1 access per 4 cycles under contention.
- Requester rule: it observes gnt at the edge ending A and must then deassert req or present the next request. The arbiter samples again in cycle A+1 (IDLE), so the next access is at A+2.
- ram_addr and ram_data hold their last issued values outside ACCESS. ram_wr is high only in A of a write.
- Read return: a read issued in cycle A pushes tag {valid, master id} into a RD_LAT-deep shift pipeline.
  - ram_q is sampled at the edge ending cycle A+RD_LAT into the tagged master's rdata.
  - That master's rvalid is high in cycle A+RD_LAT+1 for exactly one cycle.
  - The other master's rdata is unchanged.
  - Writes produce no rvalid.
- Overlap: with RD_LAT>=2, return pulses of successive reads may overlap with new grants. The pipeline handles one entry per cycle and loses no data.
- Widths: no arithmetic; addr and data are passed through unmodified.

Decomposition:
- Shared package ram_arb_pkg:
  - Constants AW=6, DW=8.
  - FSM state encoding IDLE=0, ACCESS=1.
  - Master id constants M0=0, M1=1.
- One natural sub-module, rd_tag_pipe: a parameterised RD_LAT-deep shift register of {valid, id}. The top block contains the FSM, round-robin logic and output registers.

Test Plan:
1. Reset, then m0 writes addr=5, wdata=0xA5 -> m0_gnt=1, ram_wr=1, ram_addr=5, ram_data=0xA5 in cycle A only; no m0_rvalid.
2. After 1, m1 reads addr=5 (RD_LAT=1) -> m1_gnt in A, m1_rvalid=1 in A+2 with m1_rdata=0xA5; m0_rvalid stays 0.
3. m0 and m1 both request continuously, writing m0:addr 0..3, m1:addr 32..35 -> gnts alternate m0,m1,m0,... every 2 cycles starting with m0; 8 writes done in 16 cycles.
4. Only m1 requests for 4 back-to-back reads -> m1 granted every 2 cycles; each rvalid follows its gnt by exactly RD_LAT+1 cycles with the matching data.
5. Assert rst in cycle A of a read -> gnt, ram_wr and all rvalid drop immediately; no rvalid after reset release; the first tie after reset goes to m0.
6. RD_LAT=3, alternating m0 read/m1 read -> each rvalid is routed to the correct master 4 cycles after its gnt, with no lost or duplicated pulse.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the single-port RAM arbiter.
package ram_arb_pkg;

    localparam int AW = 6;
    localparam int DW = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Read-return tag travelling alongside the RAM read latency.
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags {valid, id}; one entry per cycle.
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    localparam int SRW = 2 * RD_LAT;

    typedef logic [SRW-1:0] sr_t;

    sr_t sr;

    // Shift left by one tag each cycle; the truncating cast drops the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= sr_t'({sr, tag_in});
        end
    end

    assign tag_out = rd_tag_t'(sr[SRW-1 -: 2]);

endmodule

// File: rtl/ram_sp_arbiter.sv
// Round-robin arbiter/sequencer serialising two masters onto one RAM port.
module ram_sp_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW     = ram_arb_pkg::AW,
    parameter int DW     = ram_arb_pkg::DW,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wr,
    input  logic [DW-1:0] ram_q
);

    state_t        state, state_d;
    logic          last, last_d;
    logic          win;
    logic          gnt0_d, gnt1_d, wr_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] data_d;
    rd_tag_t       tag_in, tag_out;

    // State, round-robin pointer and registered RAM/grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= M1;
            m0_gnt   <= 1'b0;
            m1_gnt   <= 1'b0;
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end else begin
            state    <= state_d;
            last     <= last_d;
            m0_gnt   <= gnt0_d;
            m1_gnt   <= gnt1_d;
            ram_wr   <= wr_d;
            ram_addr <= addr_d;
            ram_data <= data_d;
        end
    end

    // Next state and next outputs: sample requests only in IDLE, pick the winner.
    always_comb begin
        state_d = state;
        last_d  = last;
        win     = M0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        wr_d    = 1'b0;
        addr_d  = ram_addr;
        data_d  = ram_data;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // Under contention the master that did not win last time goes.
                    win     = (m0_req && m1_req) ? ~last : m1_req;
                    last_d  = win;
                    gnt0_d  = (win == M0);
                    gnt1_d  = (win == M1);
                    wr_d    = win ? m1_wr    : m0_wr;
                    addr_d  = win ? m1_addr  : m0_addr;
                    data_d  = win ? m1_wdata : m0_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tag pushed during the access cycle of a read.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = (m0_gnt || m1_gnt) && !ram_wr;
        tag_in.id    = m1_gnt ? M1 : M0;
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Capture RAM data for the tagged master and pulse its rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= tag_out.valid && (tag_out.id == M0);
            m1_rvalid <= tag_out.valid && (tag_out.id == M1);
            if (tag_out.valid && (tag_out.id == M0)) begin
                m0_rdata <= ram_q;
            end
            if (tag_out.valid && (tag_out.id == M1)) begin
                m1_rdata <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter: two DUTs (RD_LAT=1 and RD_LAT=3) share stimulus.
module tb_ram_sp_arbiter;

    localparam int AW     = 6;
    localparam int DW     = 8;
    localparam int LAT_A  = 1;
    localparam int LAT_B  = 3;
    localparam int BUDGET = 400;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic          m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;

    logic          gnt0 [2], gnt1 [2], rv0 [2], rv1 [2], rwr [2];
    logic [DW-1:0] rd0 [2], rd1 [2], rdat [2], rq [2];
    logic [AW-1:0] radr [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] seed(input logic [AW-1:0] a);
        return {a, 2'b01} ^ 8'h3C;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? LAT_A : LAT_B;
        logic [DW-1:0] mem [64];
        logic          wrt [64];
        logic [DW-1:0] qp  [LAT];

        ram_sp_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
            .clk(clk), .rst(rst),
            .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
            .m0_gnt(gnt0[g]), .m0_rvalid(rv0[g]), .m0_rdata(rd0[g]),
            .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
            .m1_gnt(gnt1[g]), .m1_rvalid(rv1[g]), .m1_rdata(rd1[g]),
            .ram_addr(radr[g]), .ram_data(rdat[g]), .ram_wr(rwr[g]), .ram_q(rq[g])
        );

        // Synchronous RAM with LAT cycles from address sampled to q valid.
        always @(posedge clk) begin
            qp[0] <= (wrt[radr[g]] === 1'b1) ? mem[radr[g]] : seed(radr[g]);
            for (int i = 1; i < LAT; i++) qp[i] <= qp[i-1];
            if (rwr[g] === 1'b1) begin
                mem[radr[g]] <= rdat[g];
                wrt[radr[g]] <= 1'b1;
            end
        end
        assign rq[g] = qp[LAT-1];
    end

    // ---------------- reference model (transaction level) ----------------
    int            cyc = 0, cur = 0, next_sample = 0;
    logic          m_last = 1'b1, win = 1'b0;
    logic          e_g0 = 1'b0, e_g1 = 1'b0, e_wr = 1'b0;
    logic [AW-1:0] e_addr = '0, a_sel = '0;
    logic [DW-1:0] e_data = '0, d_sel = '0;
    logic [DW-1:0] mm  [64];
    bit            mmv [64];
    logic [8:0]    ret [int];   // key = due_cycle*2 + dut, value = {master, data}

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_g0 = 1'b0; e_g1 = 1'b0; e_wr = 1'b0; e_addr = '0; e_data = '0;
            m_last = 1'b1; next_sample = 0;
            ret.delete();
        end else begin
            cur = cyc;
            cyc = cyc + 1;
            e_g0 = 1'b0; e_g1 = 1'b0; e_wr = 1'b0;
            if (cur >= next_sample && (m0_req || m1_req)) begin
                win    = (m0_req && m1_req) ? ~m_last : m1_req;
                m_last = win;
                e_g0   = ~win;
                e_g1   = win;
                e_wr   = win ? m1_wr : m0_wr;
                a_sel  = win ? m1_addr : m0_addr;
                e_addr = a_sel;
                e_data = win ? m1_wdata : m0_wdata;
                next_sample = cyc + 1;
                if (e_wr) begin
                    mm[a_sel]  = e_data;
                    mmv[a_sel] = 1'b1;
                end else begin
                    d_sel = mmv[a_sel] ? mm[a_sel] : seed(a_sel);
                    ret[(cyc + LAT_A + 1) * 2 + 0] = {win, d_sel};
                    ret[(cyc + LAT_B + 1) * 2 + 1] = {win, d_sel};
                end
            end
        end
    end

    // ---------------- checking and driving ----------------
    txn_t       q0 [$], q1 [$];
    int         order [$];
    logic [DW-1:0] erd0 [2] = '{8'h00, 8'h00}, erd1 [2] = '{8'h00, 8'h00};
    int         cnt0 [2] = '{0, 0}, cnt1 [2] = '{0, 0};
    int         c0s [2], c1s [2];
    int         n, k;

    task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, g, obs, exp);
        end
    endtask

    task automatic monitor();
        logic       ev0, ev1;
        logic [8:0] e;
        for (int g = 0; g < 2; g++) begin
            ev0 = 1'b0; ev1 = 1'b0;
            if (!rst && ret.exists(cyc * 2 + g)) begin
                e = ret[cyc * 2 + g];
                if (e[8]) begin ev1 = 1'b1; erd1[g] = e[7:0]; end
                else      begin ev0 = 1'b1; erd0[g] = e[7:0]; end
            end
            if (rv0[g] === 1'b1) cnt0[g]++;
            if (rv1[g] === 1'b1) cnt1[g]++;
            chk("m0_gnt",    g, 32'(gnt0[g]), 32'(e_g0));
            chk("m1_gnt",    g, 32'(gnt1[g]), 32'(e_g1));
            chk("ram_wr",    g, 32'(rwr[g]),  32'(e_wr));
            chk("ram_addr",  g, 32'(radr[g]), 32'(e_addr));
            chk("ram_data",  g, 32'(rdat[g]), 32'(e_data));
            chk("m0_rvalid", g, 32'(rv0[g]),  32'(ev0));
            chk("m1_rvalid", g, 32'(rv1[g]),  32'(ev1));
            chk("m0_rdata",  g, 32'(rd0[g]),  32'(erd0[g]));
            chk("m1_rdata",  g, 32'(rd1[g]),  32'(erd1[g]));
        end
    endtask

    task automatic drive();
        if (m0_req && gnt0[0] === 1'b1) begin q0.delete(0); order.push_back(0); end
        if (m1_req && gnt1[0] === 1'b1) begin q1.delete(0); order.push_back(1); end
        if (q0.size() != 0) begin
            m0_req = 1'b1; m0_wr = q0[0].wr; m0_addr = q0[0].addr; m0_wdata = q0[0].data;
        end else m0_req = 1'b0;
        if (q1.size() != 0) begin
            m1_req = 1'b1; m1_wr = q1[0].wr; m1_addr = q1[0].addr; m1_wdata = q1[0].data;
        end else m1_req = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        drive();
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic drain(output int steps);
        steps = 0;
        while ((q0.size() != 0 || q1.size() != 0) && steps < BUDGET) begin
            step();
            steps++;
        end
        chk("drain_pending", -1, 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk({tag, "_m0_gnt"}, g, 32'(gnt0[g]), 32'd0);
            chk({tag, "_m1_gnt"}, g, 32'(gnt1[g]), 32'd0);
            chk({tag, "_ram_wr"}, g, 32'(rwr[g]),  32'd0);
            chk({tag, "_m0_rv"},  g, 32'(rv0[g]),  32'd0);
            chk({tag, "_m1_rv"},  g, 32'(rv1[g]),  32'd0);
            chk({tag, "_m0_rd"},  g, 32'(rd0[g]),  32'd0);
            chk({tag, "_m1_rd"},  g, 32'(rd1[g]),  32'd0);
        end
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2 check_quiet("rst");
        for (int g = 0; g < 2; g++) begin
            chk("rst_addr", g, 32'(radr[g]), 32'd0);
            chk("rst_data", g, 32'(rdat[g]), 32'd0);
        end
        @(negedge clk);
        #2 rst = 1'b0;

        // 1: m0 writes 0xA5 to address 5
        q0.push_back('{1'b1, 6'd5, 8'hA5});
        drain(n);
        for (int g = 0; g < 2; g++) begin
            chk("t1_gnt",  g, 32'(gnt0[g]), 32'd1);
            chk("t1_wr",   g, 32'(rwr[g]),  32'd1);
            chk("t1_addr", g, 32'(radr[g]), 32'd5);
            chk("t1_data", g, 32'(rdat[g]), 32'hA5);
        end
        step();
        chk("t1_gnt_off", 0, 32'(gnt0[0]), 32'd0);
        chk("t1_wr_off",  0, 32'(rwr[0]),  32'd0);
        idle(5);

        // 2: m1 reads address 5
        q1.push_back('{1'b0, 6'd5, 8'h00});
        drain(n);
        step(); step();
        chk("t2_m1_rvalid", 0, 32'(rv1[0]), 32'd1);
        chk("t2_m1_rdata",  0, 32'(rd1[0]), 32'hA5);
        chk("t2_m0_rvalid", 0, 32'(rv0[0]), 32'd0);
        step(); step();
        chk("t2_m1_rvalid", 1, 32'(rv1[1]), 32'd1);
        chk("t2_m1_rdata",  1, 32'(rd1[1]), 32'hA5);
        idle(3);

        // 3: both masters write continuously
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{1'b1, 6'(i),      8'($urandom)});
            q1.push_back('{1'b1, 6'(32 + i), 8'($urandom)});
        end
        order.delete();
        drain(n);
        chk("t3_steps", -1, 32'(n), 32'd16);
        chk("t3_count", -1, 32'(order.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("t3_order", -1, 32'(order[i]), 32'(i % 2));
        idle(3);

        // 4: m1 alone, four back-to-back reads
        for (int i = 0; i < 4; i++) q1.push_back('{1'b0, 6'(32 + i), 8'h00});
        drain(n);
        chk("t4_steps", -1, 32'(n), 32'd8);
        idle(6);

        // 6: alternating reads under contention, pulse counts per master
        for (int g = 0; g < 2; g++) begin c0s[g] = cnt0[g]; c1s[g] = cnt1[g]; end
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{1'b0, 6'(i),      8'h00});
            q1.push_back('{1'b0, 6'(32 + i), 8'h00});
        end
        drain(n);
        idle(6);
        for (int g = 0; g < 2; g++) begin
            chk("t6_m0_pulses", g, 32'(cnt0[g] - c0s[g]), 32'd4);
            chk("t6_m1_pulses", g, 32'(cnt1[g] - c1s[g]), 32'd4);
        end

        // Randomised mixed traffic over a small address window
        for (int i = 0; i < 24; i++) begin
            q0.push_back('{1'($urandom), 6'($urandom_range(0, 15)), 8'($urandom)});
            q1.push_back('{1'($urandom), 6'($urandom_range(0, 15)), 8'($urandom)});
        end
        drain(n);
        idle(6);

        // 5: reset during the access cycle of a read
        q1.push_back('{1'b0, 6'($urandom_range(0, 15)), 8'h00});
        k = 0;
        while (q1.size() != 0 && k < 20) begin step(); k++; end
        chk("t5_gnt_seen", -1, 32'(q1.size()), 32'd0);
        #2 rst = 1'b1;
        #1 check_quiet("t5_rst");
        erd0 = '{8'h00, 8'h00};
        erd1 = '{8'h00, 8'h00};
        step(); step();
        #2 rst = 1'b0;
        idle(6);
        q0.push_back('{1'b1, 6'd9, 8'h3E});
        q1.push_back('{1'b1, 6'd10, 8'hC1});
        order.delete();
        drain(n);
        chk("t5_tie_first", -1, 32'(order[0]), 32'd0);
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
